// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - fetch/decode/redirect bundle for pc_sequencer; RAS_EN adds call/ret/rasErr
interface pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pcIncr;
    logic            fetchReq;
    logic            fetchAck;
    logic [PC_W-1:0] fetchData;
    logic [PC_W-1:0] instr;
    logic            instrValid;
    logic            stall;
    logic            jump;
    logic [PC_W-1:0] jumpTarget;
    logic            branchTaken;
    logic [PC_W-1:0] branchTarget;
    logic            halt;
    logic            halted;
`ifdef RAS_EN
    logic            call;
    logic            ret;
    logic            rasErr;
`endif

    modport master (
        output pc, fetchReq, instr, instrValid, halted,
        input  pcIncr, fetchAck, fetchData, stall, jump, jumpTarget,
        input  branchTaken, branchTarget, halt
`ifdef RAS_EN
        , input call, ret, output rasErr
`endif
    );

    modport slave (
        input  pc, fetchReq, instr, instrValid, halted,
        output pcIncr, fetchAck, fetchData, stall, jump, jumpTarget,
        output branchTaken, branchTarget, halt
`ifdef RAS_EN
        , output call, ret, input rasErr
`endif
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner and fetch/decode sequencer
// Optional return-address stack enabled by defining RAS_EN.
module pc_sequencer #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALTED} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] instr_q, instr_d;

`ifdef RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    // ptr_q is the next slot to write; the newest entry sits just below it
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, top_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push, pop;
    logic             rasErr_q, rasErr_d;

    assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign top_idx = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
        rasErr_d = 1'b0;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (bus.fetchAck) begin
                    instr_d = bus.fetchData;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!bus.stall) begin
                    if (bus.halt) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
`ifdef RAS_EN
                        if (bus.call) begin
                            push = 1'b1;
                            pc_d = bus.jumpTarget;
                        end else if (bus.ret) begin
                            if (cnt_q != '0) begin
                                pop  = 1'b1;
                                pc_d = ras_q[top_idx];
                            end else begin
                                pc_d     = bus.pcIncr;
                                rasErr_d = 1'b1;
                            end
                        end else
`endif
                        if (bus.jump) begin
                            pc_d = bus.jumpTarget;
                        end else if (bus.branchTaken) begin
                            pc_d = bus.branchTarget;
                        end else begin
                            pc_d = bus.pcIncr;
                        end
                    end
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = IDLE;
        endcase
`ifdef RAS_EN
        // a push into a full stack overwrites the oldest slot and keeps the count saturated
        if (push) begin
            ptr_d = ptr_inc;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef RAS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            cnt_q    <= '0;
            rasErr_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            rasErr_q <= rasErr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_q[ptr_q] <= bus.pcIncr;
        end
    end

    assign bus.rasErr = rasErr_q;
`endif

    assign bus.pc         = pc_q;
    assign bus.instr      = instr_q;
    assign bus.fetchReq   = (state_q == FETCH);
    assign bus.instrValid = (state_q == DECODE);
    assign bus.halted     = (state_q == HALTED);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural next-pc model
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pc_sequencer_if #(.PC_W(16)) bus ();

    pc_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // external incrementer
    assign bus.pcIncr = bus.pc + 16'd1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus.stall        = 1'b0;
        bus.jump         = 1'b0;
        bus.branchTaken  = 1'b0;
        bus.halt         = 1'b0;
        bus.fetchAck     = 1'b0;
`ifdef RAS_EN
        bus.call         = 1'b0;
        bus.ret          = 1'b0;
`endif
    endtask

    task automatic do_reset();
        clear_ctrl();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // waits for a request, acks it after `delay` cycles, leaves the DUT in DECODE
    task automatic fetch_cycle(input int delay, input logic [15:0] data,
                               output logic [15:0] pc_seen, output logic [15:0] instr_seen,
                               output bit ok);
        int n = 0;
        ok = 1'b0;
        pc_seen = 'x;
        instr_seen = 'x;
        while (bus.fetchReq !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (bus.fetchReq !== 1'b1) return;
        pc_seen = bus.pc;
        repeat (delay) step();
        bus.fetchAck  = 1'b1;
        bus.fetchData = data;
        step();
        bus.fetchAck  = 1'b0;
        bus.fetchData = 16'($urandom);
        instr_seen = bus.instr;
        ok = (bus.instrValid === 1'b1);
    endtask

    task automatic test_reset();
        clear_ctrl();
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.pc !== 16'h0000 || bus.fetchReq !== 1'b0 || bus.instrValid !== 1'b0 ||
            bus.halted !== 1'b0 || bus.instr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h req=%b iv=%b halted=%b instr=%h, expected 0000 0 0 0 0000",
                     bus.pc, bus.fetchReq, bus.instrValid, bus.halted, bus.instr);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.fetchReq !== 1'b1 || bus.pc !== 16'h0000) begin
            errors++;
            $display("FAIL idle_to_fetch: req=%b pc=%h, expected 1 0000", bus.fetchReq, bus.pc);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] p, ins, d;
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            fetch_cycle(1, d, p, ins, ok);
            checks++;
            if (!ok || p !== 16'(i) || ins !== d) begin
                errors++;
                $display("FAIL seq_fetch%0d: ok=%b pc=%h instr=%h, expected 1 %h %h", i, ok, p, ins, 16'(i), d);
            end
            step();
            checks++;
            if (bus.instrValid !== 1'b0) begin
                errors++;
                $display("FAIL seq_valid_drop%0d: instrValid=%b, expected 0", i, bus.instrValid);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] p, ins, d;
        bit ok;
        do_reset();
        d = 16'hA5C3;
        fetch_cycle(0, d, p, ins, ok);
        bus.stall = 1'b1;
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h1234;
        bus.halt = 1'b1;
        bus.fetchAck = 1'b1;
        bus.fetchData = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.instr !== d || bus.pc !== 16'h0000 || bus.instrValid !== 1'b1 || bus.fetchReq !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: instr=%h pc=%h iv=%b req=%b, expected %h 0000 1 0",
                         i, bus.instr, bus.pc, bus.instrValid, bus.fetchReq, d);
            end
        end
        clear_ctrl();
        step();
        checks++;
        if (bus.pc !== 16'h0001) begin
            errors++;
            $display("FAIL stall_release: pc=%h, expected 0001", bus.pc);
        end
        step();
        checks++;
        if (bus.pc !== 16'h0001 || bus.fetchReq !== 1'b1) begin
            errors++;
            $display("FAIL stall_single_advance: pc=%h req=%b, expected 0001 1", bus.pc, bus.fetchReq);
        end
    endtask

    task automatic test_fetch_ignores_ctrl();
        logic [15:0] p, ins;
        bit ok;
        do_reset();
        step();
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h4444;
        bus.branchTaken = 1'b1;
        bus.branchTarget = 16'h5555;
        bus.halt = 1'b1;
        fetch_cycle(2, 16'h7777, p, ins, ok);
        checks++;
        if (!ok || bus.pc !== 16'h0000 || bus.halted !== 1'b0 || ins !== 16'h7777) begin
            errors++;
            $display("FAIL fetch_ignore: ok=%b pc=%h halted=%b instr=%h, expected 1 0000 0 7777",
                     ok, bus.pc, bus.halted, ins);
        end
        clear_ctrl();
        step();
    endtask

    task automatic test_priority_wrap();
        logic [15:0] p, ins;
        bit ok;
        do_reset();
        fetch_cycle(1, 16'h0001, p, ins, ok);
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h0010;
        step();
        clear_ctrl();
        fetch_cycle(1, 16'h0002, p, ins, ok);
        checks++;
        if (p !== 16'h0010) begin
            errors++;
            $display("FAIL jump_to_0010: pc=%h, expected 0010", p);
        end
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h0200;
        bus.branchTaken = 1'b1;
        bus.branchTarget = 16'h0300;
        step();
        clear_ctrl();
        fetch_cycle(0, 16'h0003, p, ins, ok);
        checks++;
        if (p !== 16'h0200) begin
            errors++;
            $display("FAIL jump_beats_branch: pc=%h, expected 0200", p);
        end
        bus.branchTaken = 1'b1;
        bus.branchTarget = 16'h0300;
        step();
        clear_ctrl();
        fetch_cycle(0, 16'h0004, p, ins, ok);
        checks++;
        if (p !== 16'h0300) begin
            errors++;
            $display("FAIL branch_taken: pc=%h, expected 0300", p);
        end
        bus.jump = 1'b1;
        bus.jumpTarget = 16'hFFFF;
        step();
        clear_ctrl();
        fetch_cycle(1, 16'h0005, p, ins, ok);
        step();
        checks++;
        if (p !== 16'hFFFF || bus.pc !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap: before=%h after=%h, expected FFFF 0000", p, bus.pc);
        end
    endtask

    task automatic test_halt();
        logic [15:0] p, ins;
        bit ok;
        do_reset();
        fetch_cycle(0, 16'h1111, p, ins, ok);
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h0005;
        step();
        clear_ctrl();
        fetch_cycle(1, 16'h2222, p, ins, ok);
        bus.halt = 1'b1;
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h0999;
        step();
        clear_ctrl();
        bus.fetchAck = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bus.halted !== 1'b1 || bus.fetchReq !== 1'b0 || bus.pc !== 16'h0005 || bus.instrValid !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold%0d: halted=%b req=%b pc=%h iv=%b, expected 1 0 0005 0",
                         i, bus.halted, bus.fetchReq, bus.pc, bus.instrValid);
            end
            step();
        end
        bus.fetchAck = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (bus.pc !== 16'h0000 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: pc=%h halted=%b, expected 0000 0", bus.pc, bus.halted);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [15:0] p, ins;
        bit ok;
        do_reset();
        fetch_cycle(0, 16'h3333, p, ins, ok);
        bus.jump = 1'b1;
        bus.jumpTarget = 16'h0040;
        step();
        clear_ctrl();
        bus.fetchAck = 1'b1;
        bus.fetchData = 16'hBEEF;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.fetchAck = 1'b0;
        checks++;
        if (bus.pc !== 16'h0000 || bus.instrValid !== 1'b0 || bus.fetchReq !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fetch: pc=%h iv=%b req=%b, expected 0000 0 0", bus.pc, bus.instrValid, bus.fetchReq);
        end
`ifdef RAS_EN
        fetch_cycle(0, 16'h0001, p, ins, ok);
        bus.ret = 1'b1;
        step();
        clear_ctrl();
        checks++;
        if (bus.pc !== 16'h0001 || bus.rasErr !== 1'b1) begin
            errors++;
            $display("FAIL ret_empty: pc=%h rasErr=%b, expected 0001 1", bus.pc, bus.rasErr);
        end
        step();
        checks++;
        if (bus.rasErr !== 1'b0) begin
            errors++;
            $display("FAIL ras_err_pulse: rasErr=%b, expected 0", bus.rasErr);
        end
`endif
    endtask

`ifdef RAS_EN
    task automatic test_ras_overflow();
        logic [15:0] p, ins, pushed[5];
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fetch_cycle(0, 16'(i), p, ins, ok);
            pushed[i] = p + 16'd1;
            bus.call = 1'b1;
            bus.ret = 1'b1;
            bus.jumpTarget = 16'($urandom);
            step();
            clear_ctrl();
        end
        for (int i = 4; i >= 1; i--) begin
            fetch_cycle(1, 16'hC0DE, p, ins, ok);
            bus.ret = 1'b1;
            step();
            clear_ctrl();
            checks++;
            if (bus.pc !== pushed[i] || bus.rasErr !== 1'b0) begin
                errors++;
                $display("FAIL ras_pop%0d: pc=%h rasErr=%b, expected %h 0", i, bus.pc, bus.rasErr, pushed[i]);
            end
        end
        fetch_cycle(0, 16'hC0DE, p, ins, ok);
        bus.ret = 1'b1;
        step();
        clear_ctrl();
        checks++;
        if (bus.pc !== p + 16'd1 || bus.rasErr !== 1'b1) begin
            errors++;
            $display("FAIL ras_underflow: pc=%h rasErr=%b, expected %h 1", bus.pc, bus.rasErr, p + 16'd1);
        end
    endtask
`endif

    // random programs against a next-pc model derived from the redirect priority rules
    task automatic test_random();
        logic [15:0] p, ins, d, exp_pc;
        logic [15:0] ras[$];
        bit ok, j, b, c, r, exp_err;
        do_reset();
        exp_pc = 16'h0000;
        for (int n = 0; n < 60; n++) begin
            d = 16'($urandom);
            fetch_cycle(int'($urandom_range(0, 3)), d, p, ins, ok);
            checks++;
            if (!ok || p !== exp_pc || ins !== d) begin
                errors++;
                $display("FAIL rand_fetch%0d: ok=%b pc=%h instr=%h, expected 1 %h %h", n, ok, p, ins, exp_pc, d);
            end
            bus.stall = 1'b1;
            repeat ($urandom_range(0, 2)) begin
                bus.jump = 1'($urandom);
                bus.halt = 1'($urandom);
                step();
            end
            j = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 2) == 0);
            c = 1'b0;
            r = 1'b0;
`ifdef RAS_EN
            c = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 3) == 0);
            bus.call = c;
            bus.ret = r;
`endif
            bus.stall = 1'b0;
            bus.halt = 1'b0;
            bus.jump = j;
            bus.branchTaken = b;
            bus.jumpTarget = 16'($urandom);
            bus.branchTarget = 16'($urandom);
            exp_err = 1'b0;
            if (c) begin
                ras.push_back(exp_pc + 16'd1);
                if (ras.size() > 4) void'(ras.pop_front());
                exp_pc = bus.jumpTarget;
            end else if (r && ras.size() > 0) begin
                exp_pc = ras.pop_back();
            end else if (r) begin
                exp_pc = exp_pc + 16'd1;
                exp_err = 1'b1;
            end else if (j) begin
                exp_pc = bus.jumpTarget;
            end else if (b) begin
                exp_pc = bus.branchTarget;
            end else begin
                exp_pc = exp_pc + 16'd1;
            end
            step();
            clear_ctrl();
`ifdef RAS_EN
            checks++;
            if (bus.rasErr !== exp_err) begin
                errors++;
                $display("FAIL rand_rasErr%0d: rasErr=%b, expected %b", n, bus.rasErr, exp_err);
            end
`endif
            checks++;
            if (bus.pc !== exp_pc || bus.instrValid !== 1'b0) begin
                errors++;
                $display("FAIL rand_next%0d: pc=%h iv=%b, expected %h 0 (err_model=%b)", n, bus.pc, bus.instrValid, exp_pc, exp_err);
            end
        end
    endtask

    initial begin
        bus.fetchData = 16'h0000;
        bus.jumpTarget = 16'h0000;
        bus.branchTarget = 16'h0000;
        clear_ctrl();
        test_reset();
        test_sequential();
        test_stall();
        test_fetch_ignores_ctrl();
        test_priority_wrap();
        test_halt();
        test_reset_mid_fetch();
`ifdef RAS_EN
        test_ras_overflow();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural program counter and drives instruction fetch.
- Sends `pc` to the external +1 incrementer and receives `pcIncr` back. This is the consumer end of the incrementer path.
- Selects the next PC from `pcIncr`, the branch target or the jump target.
- Runs a request/acknowledge fetch handshake with instruction memory and presents each fetched instruction to decode, holding it until decode releases it.

Parameters:
- PC_W, 16, width of PC, targets and instruction word.
- RESET_PC, 16'h0000, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries; used only when RAS_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on clk rising edge.
- pc  output  PC_W  current program counter; to incrementer and instruction memory address.
- pcIncr  input  PC_W  pc+1 from incrementer, combinational from `pc`.
- fetchReq  output  1  fetch request to instruction memory.
- fetchAck  input  1  memory has `fetchData` valid this cycle.
- fetchData  input  PC_W  instruction word from memory.
- instr  output  PC_W  latched instruction to decode.
- instrValid  output  1  `instr` is valid and held for decode.
- stall  input  1  decode not ready; hold current instruction.
- jump  input  1  unconditional redirect to `jumpTarget`.
- jumpTarget  input  PC_W  jump destination.
- branchTaken  input  1  conditional branch resolved taken.
- branchTarget  input  PC_W  branch destination.
- halt  input  1  stop sequencing after the current instruction.
- halted  output  1  sequencer is in HALTED.

Behaviour:
- Reset (rst_n low at an edge, in any state, including mid-handshake):
  - pc=RESET_PC, fetchReq=0, instr=0, instrValid=0, halted=0.
  - State goes to IDLE. The RAS pointer and count go to 0.
- State IDLE:
  - Lasts exactly one cycle after reset deasserts; no outputs change.
  - Next state is FETCH.
- State FETCH:
  - fetchReq=1; pc held constant.
  - fetchAck=0: stay in FETCH.
  - fetchAck=1 at an edge: instr<=fetchData, instrValid<=1, fetchReq<=0, go to DECODE.
  - fetchAck arriving in the same cycle the request first rises is legal (zero-wait memory).
  - jump, branchTaken and halt are ignored in FETCH.
- State DECODE:
  - fetchReq=0, instrValid=1, instr held.
  - stall=1: stay; pc, instr and all control inputs are ignored.
  - stall=0: the redirect inputs are sampled once.
    - Next-PC priority: halt > jump > branchTaken > sequential.
    - halt: pc held, instrValid<=0, halted<=1, go to HALTED.
    - jump: pc<=jumpTarget.
    - branchTaken: pc<=branchTarget.
    - Otherwise pc<=pcIncr.
    - In the non-halt cases instrValid<=0 and the next state is FETCH.
- State HALTED:
  - fetchReq=0, instrValid=0, halted=1; pc frozen.
  - Only reset leaves this state.
- Latency:
  - Minimum 2 cycles per instruction (FETCH with immediate ack, then DECODE).
  - The new pc is visible the cycle after DECODE exits.
- Arithmetic:
  - No adder inside this block.
  - Sequential wrap 16'hFFFF -> 16'h0000 comes from `pcIncr` (mod 2^PC_W) and is accepted unchanged.
- Simultaneous events:
  - jump and branchTaken both high: jump wins.
  - halt with jump: halt wins and no redirect occurs.
  - fetchAck outside FETCH is ignored.

Optional Feature:
- Macro: RAS_EN.
- When defined:
  - Adds inputs `call`, `ret` and output `rasErr`.
  - Adds a circular return-address stack of RAS_DEPTH entries, each PC_W wide.
- In DECODE with stall=0 and halt=0, priority is: call > ret > jump > branchTaken > sequential.
- call:
  - Push pcIncr; pc<=jumpTarget.
  - If the stack is full, the oldest entry is overwritten and the count stays at RAS_DEPTH.
- ret with count>0: pop; pc<=popped value.
- ret with count=0:
  - pc<=pcIncr.
  - rasErr pulses high for exactly 1 cycle.
- call and ret together: call wins and ret is ignored.
- rasErr resets to 0.
- When not defined: no call/ret/rasErr ports, no stack storage; behaviour exactly as above.

Test Plan:
- Reset then sequential fetch, memory acks 1 cycle after fetchReq:
  - pc goes 0x0000, 0x0001, 0x0002.
  - instrValid pulses once per instruction; instr equals the fetchData of each ack.
- In DECODE, stall=1 for 3 cycles then 0:
  - instr and pc held for 3 cycles.
  - pc advances exactly once after release.
- pc=0x0010 in DECODE with jump=1, jumpTarget=0x0200, branchTaken=1, branchTarget=0x0300:
  - Next fetch pc=0x0200.
- Load pc=0xFFFF via jump, then sequential DECODE with pcIncr=0x0000:
  - pc wraps to 0x0000.
- halt=1 in DECODE at pc=0x0005:
  - halted=1, fetchReq stays 0, pc stays 0x0005 for 10+ cycles.
  - rst_n low for one edge: pc=0x0000, halted=0.
- rst_n low while in FETCH with fetchAck pending (RAS_EN defined):
  - pc=RESET_PC, instrValid=0.
  - Next ret with empty stack: pc=pcIncr and rasErr high for 1 cycle.
  - 5 calls with RAS_DEPTH=4, then 4 rets: rets return the last 4 pushed values, newest first.
